// File: rtl/elastic_buffer_if.sv
// Valid/ready handshake bundle for elastic_buffer: producer side (*_in) and consumer side (*_out).
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface elastic_buffer_if #(
   parameter type T = logic
) ();
   logic valid_in;
   logic ready_in;
   T     data_in;
   logic valid_out;
   logic ready_out;
   T     data_out;

   modport slave (
      input  valid_in,
      input  data_in,
      input  ready_out,
      output ready_in,
      output valid_out,
      output data_out
   );

   modport master (
      output valid_in,
      output data_in,
      output ready_out,
      input  ready_in,
      input  valid_out,
      input  data_out
   );
endinterface

// File: rtl/elastic_buffer.sv
// DEPTH-entry circular elastic buffer; ready_in depends only on registered occupancy.
// Optional squash port enabled by defining ELASTIC_BUFFER_FLUSH_EN.
module elastic_buffer #(
   parameter type T     = logic,
   parameter int  DEPTH = 2,
   parameter int  CW    = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
`ifdef ELASTIC_BUFFER_FLUSH_EN
   input  logic            flush,
`endif
   elastic_buffer_if.slave bus,
   output logic [CW-1:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T              r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_empty = (r_cnt == '0);

`ifdef ELASTIC_BUFFER_FLUSH_EN
   assign bus.ready_in  = !w_full && !flush;
   assign bus.valid_out = !w_empty && !flush;
`else
   assign bus.ready_in  = !w_full;
   assign bus.valid_out = !w_empty;
`endif

   assign w_push       = bus.valid_in && bus.ready_in;
   assign w_pop        = bus.valid_out && bus.ready_out;
   assign bus.data_out = r_mem[r_rd_ptr];
   assign count        = r_cnt;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end
`ifdef ELASTIC_BUFFER_FLUSH_EN
      else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end
`endif
      else begin
         if (w_push) begin
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (w_pop && !w_push) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: DEPTH 4, 2 and 3 instances checked every cycle against a FIFO model.
// Flush scenario is exercised only when ELASTIC_BUFFER_FLUSH_EN is defined.
module tb_elastic_buffer;
   typedef logic [7:0] byte_t;

   logic clk = 1'b0;
   logic rst4 = 1'b1;
   logic rst2 = 1'b1;
   logic rst3 = 1'b1;
   logic fl4  = 1'b0;
   logic [2:0] c4;
   logic [1:0] c2;
   logic [1:0] c3;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   elastic_buffer_if #(.T(byte_t)) b4 ();
   elastic_buffer_if #(.T(byte_t)) b2 ();
   elastic_buffer_if #(.T(byte_t)) b3 ();

   elastic_buffer #(.T(byte_t), .DEPTH(4)) u4 (
      .clk   (clk),
      .reset (rst4),
`ifdef ELASTIC_BUFFER_FLUSH_EN
      .flush (fl4),
`endif
      .bus   (b4),
      .count (c4)
   );

   elastic_buffer #(.T(byte_t), .DEPTH(2)) u2 (
      .clk   (clk),
      .reset (rst2),
`ifdef ELASTIC_BUFFER_FLUSH_EN
      .flush (1'b0),
`endif
      .bus   (b2),
      .count (c2)
   );

   elastic_buffer #(.T(byte_t), .DEPTH(3)) u3 (
      .clk   (clk),
      .reset (rst3),
`ifdef ELASTIC_BUFFER_FLUSH_EN
      .flush (1'b0),
`endif
      .bus   (b3),
      .count (c3)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference FIFO per instance: element storage, head index and element count.
   byte_t mm [3][8];
   int    mh [3];
   int    mn [3];

   task automatic model_step(input int k, input int depth, input logic rst, input logic flsh,
                             input logic vin, input logic rout, input byte_t din,
                             input logic rdy, input logic vld, input byte_t dout,
                             input logic [3:0] cnt);
      logic  e_rdy;
      logic  e_vld;
      string nm;
      nm    = $sformatf("u%0d", depth);
      e_vld = (mn[k] != 0) && !flsh;
      e_rdy = (mn[k] != depth) && !flsh;
      check({nm, ".ready_in"}, {31'b0, rdy}, {31'b0, e_rdy});
      check({nm, ".valid_out"}, {31'b0, vld}, {31'b0, e_vld});
      check({nm, ".count"}, {28'b0, cnt}, mn[k]);
      if (e_vld) check({nm, ".data_out"}, {24'b0, dout}, {24'b0, mm[k][mh[k]]});
      if (rst || flsh) begin
         mh[k] = 0;
         mn[k] = 0;
      end else begin
         if (e_vld && rout) begin
            mh[k] = (mh[k] + 1) % 8;
            mn[k] = mn[k] - 1;
         end
         if (vin && e_rdy) begin
            mm[k][(mh[k] + mn[k]) % 8] = din;
            mn[k] = mn[k] + 1;
         end
      end
   endtask

   byte_t pop4[$];
   byte_t pop2[$];
   int    pop2_first  = -1;
   int    push2_first = -1;
   int    pop3_n      = 0;

   always @(negedge clk) begin
      if (cyc > 0) begin
         if (b4.valid_out && b4.ready_out && !rst4) pop4.push_back(b4.data_out);
         if (b2.valid_out && b2.ready_out && !rst2) begin
            pop2.push_back(b2.data_out);
            if (pop2_first < 0) pop2_first = cyc;
         end
         if (b2.valid_in && b2.ready_in && !rst2 && push2_first < 0) push2_first = cyc;
         if (b3.valid_out && b3.ready_out && !rst3) begin
            check("u3.scoreboard", {24'b0, b3.data_out}, {24'b0, byte_t'(pop3_n * 7 + 3)});
            pop3_n++;
         end
         model_step(0, 4, rst4, fl4, b4.valid_in, b4.ready_out, b4.data_in,
                    b4.ready_in, b4.valid_out, b4.data_out, {1'b0, c4});
         model_step(1, 2, rst2, 1'b0, b2.valid_in, b2.ready_out, b2.data_in,
                    b2.ready_in, b2.valid_out, b2.data_out, {2'b0, c2});
         model_step(2, 3, rst3, 1'b0, b3.valid_in, b3.ready_out, b3.data_in,
                    b3.ready_in, b3.valid_out, b3.data_out, {2'b0, c3});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      byte_t exp1 [5];
      logic  acc;
      bit    done;
      int    sent;
      exp1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

      b4.valid_in = 0; b4.data_in = 0; b4.ready_out = 0;
      b2.valid_in = 0; b2.data_in = 0; b2.ready_out = 0;
      b3.valid_in = 0; b3.data_in = 0; b3.ready_out = 0;
      tick();
      rst4 = 0; rst2 = 0; rst3 = 0;
      check("reset.u4.count", {29'b0, c4}, 0);
      check("reset.u4.ready_in", {31'b0, b4.ready_in}, 1);
      check("reset.u4.valid_out", {31'b0, b4.valid_out}, 0);
      check("reset.u2.count", {30'b0, c2}, 0);
      check("reset.u3.valid_out", {31'b0, b3.valid_out}, 0);

      // DEPTH=4 fill, held fifth item, drain.
      for (int i = 1; i <= 4; i++) begin
         b4.valid_in = 1; b4.data_in = byte_t'(i);
         tick();
      end
      check("fill.u4.count", {29'b0, c4}, 4);
      check("fill.u4.ready_in", {31'b0, b4.ready_in}, 0);
      b4.data_in = 8'h05;
      tick(); tick();
      check("hold.u4.count", {29'b0, c4}, 4);
      b4.ready_out = 1;
      done = 0;
      for (int t = 0; t < 20 && !done; t++) begin
         @(negedge clk); acc = b4.valid_in && b4.ready_in;
         @(posedge clk); #1;
         if (acc) begin b4.valid_in = 0; done = 1; end
      end
      check("fill.u4.push5_accepted", {31'b0, done}, 1);
      for (int t = 0; t < 20 && pop4.size() < 5; t++) tick();
      check("fill.u4.pop_count", pop4.size(), 5);
      for (int i = 0; i < 5 && i < pop4.size(); i++)
         check($sformatf("fill.u4.pop[%0d]", i), {24'b0, pop4[i]}, {24'b0, exp1[i]});
      b4.ready_out = 0;
      tick();

`ifdef ELASTIC_BUFFER_FLUSH_EN
      for (int i = 0; i < 3; i++) begin
         b4.valid_in = 1; b4.data_in = byte_t'(8'h21 + i);
         tick();
      end
      check("flush.u4.count_before", {29'b0, c4}, 3);
      fl4 = 1; b4.data_in = 8'h24;
      #1;
      check("flush.u4.ready_in_comb", {31'b0, b4.ready_in}, 0);
      check("flush.u4.valid_out_comb", {31'b0, b4.valid_out}, 0);
      tick();
      fl4 = 0; b4.valid_in = 0;
      check("flush.u4.count_after", {29'b0, c4}, 0);
      check("flush.u4.valid_after", {31'b0, b4.valid_out}, 0);
      pop4.delete();
      b4.valid_in = 1; b4.data_in = 8'h25;
      tick();
      b4.valid_in = 0; b4.ready_out = 1;
      tick(); tick(); tick();
      check("flush.u4.pop_count", pop4.size(), 1);
      if (pop4.size() > 0) check("flush.u4.pop[0]", {24'b0, pop4[0]}, 32'h25);
      b4.ready_out = 0;
      tick();
`endif

      // Reset at count=2 with a live handshake.
      for (int i = 0; i < 2; i++) begin
         b4.valid_in = 1; b4.data_in = byte_t'(8'h11 * (i + 1));
         tick();
      end
      check("rst.u4.count_before", {29'b0, c4}, 2);
      rst4 = 1; b4.data_in = 8'h33; b4.ready_out = 1;
      tick();
      rst4 = 0; b4.valid_in = 0; b4.ready_out = 0;
      check("rst.u4.count", {29'b0, c4}, 0);
      check("rst.u4.valid_out", {31'b0, b4.valid_out}, 0);
      check("rst.u4.ready_in", {31'b0, b4.ready_in}, 1);
      pop4.delete();
      b4.valid_in = 1; b4.data_in = 8'h0A; tick();
      b4.data_in = 8'h0B; tick();
      b4.valid_in = 0; b4.ready_out = 1;
      tick(); tick(); tick(); tick();
      check("rst.u4.pop_count", pop4.size(), 2);
      if (pop4.size() == 2) begin
         check("rst.u4.pop[0]", {24'b0, pop4[0]}, 32'h0A);
         check("rst.u4.pop[1]", {24'b0, pop4[1]}, 32'h0B);
      end

      // DEPTH=2 continuous streaming 0..99.
      b2.ready_out = 1;
      for (int i = 0; i < 100; i++) begin
         b2.valid_in = 1; b2.data_in = byte_t'(i);
         tick();
         check("stream.u2.count", {30'b0, c2}, 1);
         check("stream.u2.ready_in", {31'b0, b2.ready_in}, 1);
      end
      b2.valid_in = 0;
      tick(); tick(); tick();
      check("stream.u2.latency", pop2_first, push2_first + 1);
      check("stream.u2.pop_count", pop2.size(), 100);
      for (int i = 0; i < 100 && i < pop2.size(); i++)
         check($sformatf("stream.u2.pop[%0d]", i), {24'b0, pop2[i]}, i);

      // DEPTH=2 full with simultaneous valid_in and ready_out.
      pop2.delete();
      b2.ready_out = 0;
      b2.valid_in = 1; b2.data_in = 8'h40; tick();
      b2.data_in = 8'h41; tick();
      check("full.u2.count", {30'b0, c2}, 2);
      b2.data_in = 8'h42; b2.ready_out = 1;
      #1;
      check("full.u2.ready_in_while_full", {31'b0, b2.ready_in}, 0);
      tick();
      check("full.u2.count_after_pop", {30'b0, c2}, 1);
      check("full.u2.ready_in_after_pop", {31'b0, b2.ready_in}, 1);
      tick();
      b2.valid_in = 0;
      check("full.u2.count_after_push", {30'b0, c2}, 1);
      tick(); tick(); tick();
      check("full.u2.pop_count", pop2.size(), 3);
      if (pop2.size() == 3) begin
         check("full.u2.pop[0]", {24'b0, pop2[0]}, 32'h40);
         check("full.u2.pop[1]", {24'b0, pop2[1]}, 32'h41);
         check("full.u2.pop[2]", {24'b0, pop2[2]}, 32'h42);
      end

      // DEPTH=3 random traffic, 1000 items.
      sent = 0;
      for (int t = 0; t < 8000 && (sent < 1000 || pop3_n < 1000); t++) begin
         if (!b3.valid_in && sent < 1000 && $urandom_range(0, 3) != 0) begin
            b3.valid_in = 1;
            b3.data_in  = byte_t'(sent * 7 + 3);
         end
         b3.ready_out = ($urandom_range(0, 2) != 0);
         @(negedge clk); acc = b3.valid_in && b3.ready_in;
         @(posedge clk); #1;
         if (acc) begin sent++; b3.valid_in = 0; end
      end
      b3.valid_in = 0; b3.ready_out = 0;
      check("random.u3.sent", sent, 1000);
      check("random.u3.popped", pop3_n, 1000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/elastic_buffer.md
# elastic_buffer

Parametrised multi-entry elastic buffer for valid/ready pipeline stages. It generalises the single-entry skid stage to DEPTH entries with a generic payload type. ready_in is a function of registered state only, so no combinational path runs from ready_out to ready_in. Optional flush supports squash on redirect. It sits between OoO pipeline stages (fetch→decode, decode→rename, issue queues), wherever timing isolation or rate decoupling is needed.

## Interface
- T, default logic: payload type.
- DEPTH, default 2: number of entries; legal range ≥2, not required to be a power of two.
- CW, derived: $clog2(DEPTH+1), the width of count.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  squash all contents. Present only with ELASTIC_BUFFER_FLUSH_EN.
- valid_in  in  1  producer has data.
- ready_in  out  1  buffer can accept data.
- data_in  in  T  producer payload.
- valid_out  out  1  buffer holds data.
- ready_out  in  1  consumer accepts data.
- data_out  out  T  oldest entry.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: circular array mem[DEPTH], write pointer wr_ptr, read pointer rd_ptr, occupancy register cnt.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two masking.
- push = valid_in && ready_in. pop = valid_out && ready_out.
- ready_in = (cnt != DEPTH). It never depends on valid_in, ready_out or data_in.
- valid_out = (cnt != 0).
- data_out = mem[rd_ptr]. It is a don't-care when valid_out=0.
- On push: mem[wr_ptr] <= data_in, and wr_ptr advances.
- On pop: rd_ptr advances.
- cnt next value: cnt + push − pop. Push and pop together leave cnt unchanged.
- FIFO order is strict. No reordering and no bypass: data written this cycle is visible at data_out from the next cycle at the earliest.
- mem is never reset. Pointers and cnt are reset.
- Producer rule: data_in must be held stable while valid_in=1 && ready_in=0. Consumer rule is the same for data_out while valid_out=1 && ready_out=0. The buffer guarantees data_out stable while stalled.

## Timing
- Reset values:
  - cnt=0, wr_ptr=0, rd_ptr=0
  - ready_in=1, valid_out=0, count=0
  - data_out undefined
- Reset mid-operation: all contents are discarded in one cycle. Any handshake in the reset cycle is ignored.
- Latency: a push in cycle N makes valid_out=1 in cycle N+1 (empty case).
- Throughput: 1 transfer per cycle in steady state with valid_in=ready_out=1. cnt holds at 1.
- Full (cnt=DEPTH):
  - ready_in=0 even if ready_out=1 in the same cycle.
  - After a pop, ready_in=1 in the next cycle.
  - Max loss is one bubble per full→drain transition.
- Empty (cnt=0): valid_out=0. A valid_in push is accepted; no pop occurs.
- Simultaneous push and pop at cnt=1: the entry is replaced correctly; data_out shows the new item the next cycle.
- Wrap: a pointer at DEPTH-1 advances to 0 on the same edge that other state updates.

## Configuration
- ELASTIC_BUFFER_FLUSH_EN defined:
  - flush port exists and takes priority over push and pop.
  - In a flush cycle: ready_in=0 and valid_out=0 combinationally, so no handshake completes.
  - Next edge: cnt=0, wr_ptr=0, rd_ptr=0.
  - reset overrides flush.
- ELASTIC_BUFFER_FLUSH_EN undefined: no flush port and no flush logic. Behaviour is otherwise identical.

## Test plan
- DEPTH=4, ready_out=0, push 0x1,0x2,0x3,0x4 → count=4 and ready_in=0 after the 4th. A 5th valid_in 0x5 is held and not accepted. Then ready_out=1 → pops 0x1..0x4 in order, and 0x5 is accepted the cycle after ready_in returns 1.
- DEPTH=2, continuous valid_in=ready_out=1 with 0..99 → one output per cycle and first output one cycle after the first push. Sequence 0..99 is exact, count stays 1, and ready_in is never deasserted.
- DEPTH=3 (non-power-of-two), random valid_in/ready_out over 1000 items → scoreboard matches in order. Pointers wrap 2→0, count is always ≤3, and data_out is stable during stalls.
- Full DEPTH=2 with ready_out=1 and valid_in=1 in the same cycle → pop occurs, no push, count=1. Next cycle ready_in=1 and the push completes.
- With ELASTIC_BUFFER_FLUSH_EN, DEPTH=4, count=3, flush=1 with valid_in=1 → no push that cycle. Next cycle count=0 and valid_out=0, and the next push returns only the new data.
- reset=1 asserted at count=2 with an active handshake → next cycle count=0, valid_out=0, ready_in=1. Subsequent items 0xA, 0xB pop in order with no stale data.
